// File: rtl/prog_memory_loader_if.sv
// Loader byte stream plus the processor's memory ports, bundled for prog_memory_loader.
interface prog_memory_loader_if #(parameter int n = 8);
  logic         load_start;
  logic         ld_valid;
  logic [n-1:0] ld_data;
  logic         ld_ready;
  logic         load_done;
  logic         load_err;
  logic         cpu_reset;
  logic [n-1:0] mem_rd_addr1;
  logic [n-1:0] mem_rd_data1;
  logic [n-1:0] mem_rd_addr2;
  logic [n-1:0] mem_rd_data2;
  logic         mem_wr_en;
  logic [n-1:0] mem_wr_addr;
  logic [n-1:0] mem_wr_data;

  modport master (
    output load_start, ld_valid, ld_data,
    output mem_rd_addr1, mem_rd_addr2, mem_wr_en, mem_wr_addr, mem_wr_data,
    input  ld_ready, load_done, load_err, cpu_reset, mem_rd_data1, mem_rd_data2
  );

  modport slave (
    input  load_start, ld_valid, ld_data,
    input  mem_rd_addr1, mem_rd_addr2, mem_wr_en, mem_wr_addr, mem_wr_data,
    output ld_ready, load_done, load_err, cpu_reset, mem_rd_data1, mem_rd_data2
  );
endinterface

// File: rtl/prog_memory_loader.sv
// Unified instruction/data memory with a checksum-verified byte-serial program loader
// that holds the processor in reset until a good image has been streamed in.
module prog_memory_loader #(
  parameter int n = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  prog_memory_loader_if.slave  bus
);
  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR, ST_DATA, ST_CSUM, ST_RUN, ST_ERR
  } state_t;

  localparam int DEPTH = 2 ** n;

  state_t         state_q, state_d;
  logic [n-1:0]   ptr_q, ptr_d;
  logic [n-1:0]   sum_q, sum_d;
  logic [n:0]     cnt_q, cnt_d;
  logic           cpu_reset_q, cpu_reset_d;
  logic           ld_ready_q, ld_ready_d;
  logic           load_done_q, load_done_d;
  logic           load_err_q, load_err_d;

  logic [n-1:0]   mem_q [DEPTH];
  logic           wr_en;
  logic [n-1:0]   wr_addr, wr_data;
  logic           xfer;

  assign xfer = bus.ld_valid & ld_ready_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      cpu_reset_q <= 1'b1;
      ld_ready_q  <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      cpu_reset_q <= cpu_reset_d;
      ld_ready_q  <= ld_ready_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  // load_start overrides everything, including a transfer in the same cycle
  always_comb begin
    state_d = state_q;
    if (bus.load_start) begin
      state_d = ST_HDR;
    end else begin
      case (state_q)
        ST_HDR:  if (xfer) state_d = ST_DATA;
        ST_DATA: if (xfer && cnt_q == (n+1)'(1)) state_d = ST_CSUM;
        ST_CSUM: if (xfer) state_d = (bus.ld_data == sum_q) ? ST_RUN : ST_ERR;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_addr = bus.mem_wr_addr;
    wr_data = bus.mem_wr_data;
    if (bus.load_start) begin
      ptr_d = '0;
      sum_d = '0;
    end else if (state_q == ST_HDR && xfer) begin
      // A zero length byte encodes a full-depth image
      cnt_d = (bus.ld_data == '0) ? {1'b1, {n{1'b0}}} : {1'b0, bus.ld_data};
    end else if (state_q == ST_DATA && xfer) begin
      wr_en   = 1'b1;
      wr_addr = ptr_q;
      wr_data = bus.ld_data;
      ptr_d   = ptr_q + n'(1);
      sum_d   = sum_q + bus.ld_data;
      cnt_d   = cnt_q - (n+1)'(1);
    end else if (state_q == ST_RUN && bus.mem_wr_en) begin
      wr_en = 1'b1;
    end
    ld_ready_d  = (state_d == ST_HDR) || (state_d == ST_DATA) || (state_d == ST_CSUM);
    load_done_d = (state_d == ST_RUN);
    load_err_d  = (state_d == ST_ERR);
    cpu_reset_d = (state_d != ST_RUN);
  end

  // Array is never reset; reads see the pre-edge contents during a write
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign bus.mem_rd_data1 = mem_q[bus.mem_rd_addr1];
  assign bus.mem_rd_data2 = mem_q[bus.mem_rd_addr2];
  assign bus.ld_ready     = ld_ready_q;
  assign bus.load_done    = load_done_q;
  assign bus.load_err     = load_err_q;
  assign bus.cpu_reset    = cpu_reset_q;
endmodule
